// File: rtl/alarm_indicator_driver_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm indicator driver:
//   - mode encodings written by software into the output PIO
//   - the indicator state enum
//   - helpers that turn rates/durations into clock-cycle counts
// No ports (package).
// -----------------------------------------------------------------------------
package alarm_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_OFF   = 2'b00;
  localparam mode_t MODE_ARMED = 2'b01;
  localparam mode_t MODE_ALARM = 2'b10;
  localparam mode_t MODE_TEST  = 2'b11;

  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_ARMED     = 3'd1,
    ST_ALARM     = 3'd2,
    ST_TEST_BEEP = 3'd3,
    ST_TEST_DONE = 3'd4
  } state_t;

  // Half-period in clock cycles of a square wave running at rate_hz.
  function automatic int half_period(input int clk_hz, input int rate_hz);
    return clk_hz / (2 * rate_hz);
  endfunction

  // clk_hz * num / den evaluated in 64 bits so long durations do not overflow.
  function automatic int scaled_cycles(input int clk_hz, input int num, input int den);
    longint v;
    v = (longint'(clk_hz) * longint'(num)) / longint'(den);
    return int'(v);
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Mode that a given state represents; both test states belong to MODE_TEST.
  function automatic mode_t state_mode(input state_t s);
    case (s)
      ST_OFF:       return MODE_OFF;
      ST_ARMED:     return MODE_ARMED;
      ST_ALARM:     return MODE_ALARM;
      ST_TEST_BEEP: return MODE_TEST;
      ST_TEST_DONE: return MODE_TEST;
      default:      return MODE_OFF;
    endcase
  endfunction

  // State entered when mode_q changes to m.
  function automatic state_t entry_state(input mode_t m);
    case (m)
      MODE_OFF:   return ST_OFF;
      MODE_ARMED: return ST_ARMED;
      MODE_ALARM: return ST_ALARM;
      MODE_TEST:  return ST_TEST_BEEP;
      default:    return ST_OFF;
    endcase
  endfunction

endpackage

// File: rtl/alarm_indicator_driver_if.sv
// -----------------------------------------------------------------------------
// alarm_indicator_driver_if
// Bundles the software mode input with the indicator pins and status flag.
//   mode         : alarm mode from the output PIO
//   led          : status LED, active-high
//   buzzer       : buzzer drive, active-high square wave
//   alarm_active : high while in ALARM (software readback)
// Modports: master = software/board side, slave = the indicator driver.
// -----------------------------------------------------------------------------
interface alarm_indicator_driver_if;
  import alarm_pkg::*;

  mode_t mode;
  logic  led;
  logic  buzzer;
  logic  alarm_active;

  modport master (output mode, input led, input buzzer, input alarm_active);
  modport slave  (input mode, output led, output buzzer, output alarm_active);
endinterface

// File: rtl/alarm_indicator_driver_tick.sv
// -----------------------------------------------------------------------------
// alarm_tick_gen
// Free-running prescaler producing a 50% duty phase bit. The count wraps from
// HALF_PERIOD-1 to 0, toggling phase at each wrap.
//   clk   : system clock
//   reset : synchronous active-high reset
//   clear : synchronous restart of count and phase (pattern starts low)
//   phase : current half-period phase
// -----------------------------------------------------------------------------
module alarm_tick_gen
  import alarm_pkg::*;
#(
  parameter int HALF_PERIOD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic phase
);

  localparam int CNT_W = cnt_width(HALF_PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  if (HALF_PERIOD < 1) begin : g_bad_half_period
    $error("alarm_tick_gen: HALF_PERIOD must be at least 1");
  end

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  // Prescaler count and phase toggle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (r_cnt == LAST) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/alarm_indicator_driver.sv
// -----------------------------------------------------------------------------
// alarm_indicator_driver
// Decodes the software alarm mode into LED blink and buzzer tone patterns.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : alarm_indicator_driver_if.slave (mode in; led, buzzer,
//           alarm_active out, all outputs registered)
// Optional feature macro: ALARM_AUTO_SILENCE_EN -- mutes the buzzer after
// SILENCE_S seconds in ALARM until ALARM is left and re-entered.
// Pipeline: mode -> mode_q -> state -> output registers.
// -----------------------------------------------------------------------------
module alarm_indicator_driver
  import alarm_pkg::*;
#(
  parameter int CLK_HZ        = 50000000,
  parameter int TONE_HZ       = 2000,
  parameter int SLOW_BLINK_HZ = 1,
  parameter int FAST_BLINK_HZ = 4,
  parameter int BEEP_MS       = 200,
  parameter int SILENCE_S     = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  alarm_indicator_driver_if.slave  bus
);

  localparam int TONE_HALF   = half_period(CLK_HZ, TONE_HZ);
  localparam int SLOW_HALF   = half_period(CLK_HZ, SLOW_BLINK_HZ);
  localparam int FAST_HALF   = half_period(CLK_HZ, FAST_BLINK_HZ);
  localparam int BEEP_CYC    = scaled_cycles(CLK_HZ, BEEP_MS, 1000);
  localparam int SILENCE_CYC = scaled_cycles(CLK_HZ, SILENCE_S, 1);

  localparam int BEEP_W = cnt_width(BEEP_CYC);
  localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_CYC - 1);

  if (BEEP_CYC < 1 || SILENCE_CYC < 1) begin : g_bad_duration
    $error("alarm_indicator_driver: beep and silence durations must be at least 1 cycle");
  end

  mode_t             r_mode_q;
  state_t            r_state;
  state_t            w_next_state;
  logic              w_clear;
  logic [BEEP_W-1:0] r_beep_cnt;
  logic              w_tone;
  logic              w_slow;
  logic              w_fast;
  logic              w_muted;
  logic              w_led;
  logic              w_buzzer;
  logic              w_alarm_active;
  logic              r_led;
  logic              r_buzzer;
  logic              r_alarm_active;

  // Single registration of the software mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode_q <= MODE_OFF;
    end else begin
      r_mode_q <= bus.mode;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state: a mode_q that no longer matches the state wins over beep
  // completion, which is what aborts a beep on a mode change.
  always_comb begin
    w_next_state = r_state;
    if (state_mode(r_state) != r_mode_q) begin
      w_next_state = entry_state(r_mode_q);
    end else if (r_state == ST_TEST_BEEP && r_beep_cnt == BEEP_LAST) begin
      w_next_state = ST_TEST_DONE;
    end else begin
      w_next_state = r_state;
    end
  end

  // Restart every pattern on the edge the state changes so each new state
  // begins at count 0, phase low.
  assign w_clear = (w_next_state != r_state);

  // Beep duration counter, only advancing during TEST_BEEP.
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_beep_cnt <= '0;
    end else if (r_state == ST_TEST_BEEP) begin
      r_beep_cnt <= r_beep_cnt + BEEP_W'(1);
    end else begin
      r_beep_cnt <= r_beep_cnt;
    end
  end

`ifdef ALARM_AUTO_SILENCE_EN
  localparam int SIL_W = cnt_width(SILENCE_CYC);
  localparam logic [SIL_W-1:0] SIL_LAST = SIL_W'(SILENCE_CYC - 1);

  logic [SIL_W-1:0] r_sil_cnt;
  logic             r_muted;

  // Auto-silence timer; the mute latches until the state changes.
  always_ff @(posedge clk) begin
    if (reset || w_clear) begin
      r_sil_cnt <= '0;
      r_muted   <= 1'b0;
    end else if (r_state == ST_ALARM && !r_muted) begin
      if (r_sil_cnt == SIL_LAST) begin
        r_muted <= 1'b1;
      end else begin
        r_sil_cnt <= r_sil_cnt + SIL_W'(1);
      end
    end else begin
      r_sil_cnt <= r_sil_cnt;
      r_muted   <= r_muted;
    end
  end

  assign w_muted = r_muted;
`else
  assign w_muted = 1'b0;
`endif

  alarm_tick_gen #(.HALF_PERIOD(TONE_HALF)) u_tone (
    .clk(clk), .reset(reset), .clear(w_clear), .phase(w_tone)
  );
  alarm_tick_gen #(.HALF_PERIOD(SLOW_HALF)) u_slow (
    .clk(clk), .reset(reset), .clear(w_clear), .phase(w_slow)
  );
  alarm_tick_gen #(.HALF_PERIOD(FAST_HALF)) u_fast (
    .clk(clk), .reset(reset), .clear(w_clear), .phase(w_fast)
  );

  // Pattern decode per state.
  always_comb begin
    w_led          = 1'b0;
    w_buzzer       = 1'b0;
    w_alarm_active = 1'b0;
    case (r_state)
      ST_OFF: begin
        w_led    = 1'b0;
        w_buzzer = 1'b0;
      end
      ST_ARMED: begin
        w_led    = w_slow;
        w_buzzer = 1'b0;
      end
      ST_ALARM: begin
        w_led          = w_fast;
        w_buzzer       = w_tone & w_fast & ~w_muted;
        w_alarm_active = 1'b1;
      end
      ST_TEST_BEEP: begin
        w_led    = 1'b1;
        w_buzzer = w_tone;
      end
      ST_TEST_DONE: begin
        w_led    = 1'b0;
        w_buzzer = 1'b0;
      end
      default: begin
        w_led          = 1'b0;
        w_buzzer       = 1'b0;
        w_alarm_active = 1'b0;
      end
    endcase
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led          <= 1'b0;
      r_buzzer       <= 1'b0;
      r_alarm_active <= 1'b0;
    end else begin
      r_led          <= w_led;
      r_buzzer       <= w_buzzer;
      r_alarm_active <= w_alarm_active;
    end
  end

  assign bus.led          = r_led;
  assign bus.buzzer       = r_buzzer;
  assign bus.alarm_active = r_alarm_active;

endmodule

// File: tb/tb_alarm_indicator_driver.sv
// -----------------------------------------------------------------------------
// tb_alarm_indicator_driver
// Drives mode/reset sequences and compares the pins every cycle against a
// reference that derives the expected pattern from the applied mode history:
// the output after edge n reflects the mode applied two edges earlier, and
// the pattern phase is the time elapsed since that mode value started.
// -----------------------------------------------------------------------------
module tb_alarm_indicator_driver;
  import alarm_pkg::*;

  localparam int P_CLK_HZ  = 1000;
  localparam int P_TONE_HZ = 100;
  localparam int P_SLOW_HZ = 1;
  localparam int P_FAST_HZ = 4;
  localparam int P_BEEP_MS = 200;
  localparam int P_SIL_S   = 2;

  localparam int TONE_H  = P_CLK_HZ / (2 * P_TONE_HZ);   // 5
  localparam int SLOW_H  = P_CLK_HZ / (2 * P_SLOW_HZ);   // 500
  localparam int FAST_H  = P_CLK_HZ / (2 * P_FAST_HZ);   // 125
  localparam int BEEP_N  = P_BEEP_MS * P_CLK_HZ / 1000;  // 200
  localparam int SIL_N   = P_SIL_S * P_CLK_HZ;           // 2000
  localparam int MAXC    = 40000;

`ifdef ALARM_AUTO_SILENCE_EN
  localparam bit SIL_EN = 1'b1;
`else
  localparam bit SIL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  alarm_indicator_driver_if bus ();

  alarm_indicator_driver #(
    .CLK_HZ(P_CLK_HZ), .TONE_HZ(P_TONE_HZ), .SLOW_BLINK_HZ(P_SLOW_HZ),
    .FAST_BLINK_HZ(P_FAST_HZ), .BEEP_MS(P_BEEP_MS), .SILENCE_S(P_SIL_S)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int    eff_mode  [MAXC];
  bit    rst_hist  [MAXC];
  int    run_start [MAXC];
  int    n_cyc = 0;
  int    vectors = 0;
  int    miscompares = 0;
  string cur_test = "none";

  // Expected {led, buzzer, alarm_active} after edge n.
  function automatic logic [2:0] expect_out(input int n);
    int  k;
    int  e;
    logic l;
    logic b;
    if (n < 2) return 3'b000;
    if (rst_hist[n] || rst_hist[n-1]) return 3'b000;
    k = n - 2;
    e = k - run_start[k];
    case (eff_mode[k])
      0: return 3'b000;
      1: return {((e / SLOW_H) % 2) == 1, 1'b0, 1'b0};
      2: begin
        l = ((e / FAST_H) % 2) == 1;
        b = l && (((e / TONE_H) % 2) == 1) && !(SIL_EN && e >= SIL_N);
        return {l, b, 1'b1};
      end
      3: begin
        if (e < BEEP_N) return {1'b1, ((e / TONE_H) % 2) == 1, 1'b0};
        return 3'b000;
      end
      default: return 3'b000;
    endcase
  endfunction

  // Apply one cycle of stimulus, then check all three pins.
  task automatic step(input logic [1:0] m, input logic r);
    logic [2:0] exp_v;
    bus.mode = m;
    reset    = r;
    @(posedge clk);
    #1;
    rst_hist[n_cyc] = r;
    eff_mode[n_cyc] = r ? 0 : int'(m);
    if (n_cyc == 0 || eff_mode[n_cyc] != eff_mode[n_cyc-1])
      run_start[n_cyc] = n_cyc;
    else
      run_start[n_cyc] = run_start[n_cyc-1];
    exp_v = expect_out(n_cyc);
    vectors++;
    if (bus.led !== exp_v[2]) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s.led cycle %0d: got %b expected %b", cur_test, n_cyc, bus.led, exp_v[2]);
    end
    if (bus.buzzer !== exp_v[1]) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s.buzzer cycle %0d: got %b expected %b", cur_test, n_cyc, bus.buzzer, exp_v[1]);
    end
    if (bus.alarm_active !== exp_v[0]) begin
      miscompares++;
      if (miscompares <= 40)
        $display("FAIL %s.alarm_active cycle %0d: got %b expected %b", cur_test, n_cyc, bus.alarm_active, exp_v[0]);
    end
    n_cyc++;
  endtask

  task automatic hold(input logic [1:0] m, input int cycles);
    for (int i = 0; i < cycles; i++) step(m, 1'b0);
  endtask

  task automatic test_reset();
    cur_test = "test_reset";
    for (int i = 0; i < 3; i++) step(MODE_ALARM, 1'b1);
    hold(MODE_ALARM, 400);
  endtask

  task automatic test_armed();
    cur_test = "test_armed";
    hold(MODE_OFF, 5);
    hold(MODE_ARMED, 2100);
    hold(MODE_OFF, 5);
  endtask

  task automatic test_test_beep();
    cur_test = "test_test_beep";
    hold(MODE_TEST, 1000);
    hold(MODE_OFF, 5);
  endtask

  task automatic test_beep_abort();
    cur_test = "test_beep_abort";
    hold(MODE_TEST, 50);
    hold(MODE_OFF, 300);
  endtask

  task automatic test_glitch();
    cur_test = "test_glitch";
    hold(MODE_ALARM, 200);
    hold(MODE_ARMED, 1);
    hold(MODE_ALARM, 200);
    hold(MODE_TEST, 300);
    hold(MODE_ALARM, 1);
    hold(MODE_TEST, 250);
  endtask

  task automatic test_reset_mid_alarm();
    cur_test = "test_reset_mid_alarm";
    hold(MODE_ALARM, 300);
    step(MODE_ALARM, 1'b1);
    hold(MODE_ALARM, 300);
  endtask

  task automatic test_silence();
    cur_test = "test_silence";
    hold(MODE_OFF, 5);
    hold(MODE_ALARM, 3000);
    hold(MODE_OFF, 5);
    hold(MODE_ALARM, 300);
  endtask

  task automatic test_random();
    logic [1:0] m;
    int         len;
    cur_test = "test_random";
    for (int s = 0; s < 40; s++) begin
      m   = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 400);
      if ($urandom_range(0, 9) == 0) step(m, 1'b1);
      hold(m, len);
    end
  endtask

  initial begin
    bus.mode = MODE_OFF;
    reset    = 1'b1;
    test_reset();
    test_armed();
    test_test_beep();
    test_beep_abort();
    test_glitch();
    test_reset_mid_alarm();
    test_silence();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
